// File: rtl/i2c_pkg.sv
// Shared types and constants for the codec-control I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, A_ACK, B1, K1, B2, K2, EXTRA, IGNORE
  } state_e;

  localparam logic [6:0] CODEC_ADDR = 7'h1A;

  // The 16-bit payload splits into a 7-bit register address and 9-bit data.
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 9;
  localparam int DATA_MSB = 8;
  localparam int DATA_LSB = 0;

  function automatic logic in_frame(state_e s);
    return (s == A_ACK) || (s == B1) || (s == K1) || (s == B2) || (s == K2);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes one bus line and produces registered level plus rise/fall pulses.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic level_q, rise_q, fall_q;

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], line_i};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target decoding 3-byte codec control frames into a register
// write strobe; ACKs its own address and the two payload bytes.
module i2c_codec_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CODEC_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       i2c_sclk,
  inout  wire logic  i2c_sdat,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       wr_en,
  output logic       busy,
  output logic       abort
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clock(clock), .rst(rst), .line_i(i2c_sclk),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clock(clock), .rst(rst), .line_i(i2c_sdat),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hi_q, hi_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d;
  logic       sda_oe_q, sda_oe_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] reg_data_q, reg_data_d;
  logic       wr_en_q, wr_en_d;
  logic       busy_q, busy_d;
  logic       abort_q, abort_d;
  logic       bus_start, bus_stop;
  logic [15:0] word;

  // SCL must be steady high around the SDA edge for it to count as START/STOP.
  assign bus_start = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign bus_stop  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
  assign word      = {hi_q, shift_q};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hi_q       <= '0;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      sda_oe_q   <= sda_oe_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    bit_cnt_d  = bit_cnt_q;
    full_d     = full_q;
    sda_oe_d   = sda_oe_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    wr_en_d    = 1'b0;
    busy_d     = busy_q;
    abort_d    = 1'b0;

    if (bus_start || bus_stop) begin
      abort_d   = in_frame(state_q);
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      state_d   = bus_start ? ADDR : IDLE;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == B1 || state_q == B2)) begin
        shift_d   = {shift_q[6:0], sda_lvl};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) full_d = 1'b1;
      end
      // Byte decisions and ACK drive/release all happen on SCL falling edges.
      if (scl_fall) begin
        unique case (state_q)
          ADDR: if (full_q) begin
            full_d = 1'b0;
            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
              state_d  = A_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
          A_ACK: begin
            state_d  = B1;
            sda_oe_d = 1'b0;
          end
          B1: if (full_q) begin
            full_d   = 1'b0;
            hi_d     = shift_q;
            state_d  = K1;
            sda_oe_d = 1'b1;
          end
          K1: begin
            state_d  = B2;
            sda_oe_d = 1'b0;
          end
          B2: if (full_q) begin
            full_d   = 1'b0;
            state_d  = K2;
            sda_oe_d = 1'b1;
          end
          K2: begin
            state_d    = EXTRA;
            sda_oe_d   = 1'b0;
            wr_en_d    = 1'b1;
            reg_addr_d = word[ADDR_MSB:ADDR_LSB];
            reg_data_d = word[DATA_MSB:DATA_LSB];
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign abort    = abort_q;

endmodule

// File: doc/i2c_codec_target.md
# i2c_codec_target

I2C write-only target (responder) that decodes the 3-byte codec control frames our configuration master emits: device address byte, then a 16-bit word holding a 7-bit register address and 9-bit register data. It oversamples the bus on the system clock, ACKs addressed frames, and presents each completed write as a one-cycle strobe. It is used as an on-FPGA register sink and as a bus-accurate codec stand-in for loopback testing of the configuration path.

## Interface
- DEV_ADDR, 7'h1A: 7-bit target address. Write byte on the wire is 8'h34.
- SYNC_STAGES, 2: synchronizer depth on SCL/SDA inputs, minimum 2.
- clock  in  1  system clock; must be ≥ 20× SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- i2c_sclk  in  1  bus clock from the master.
- i2c_sdat  inout  1  open-drain data. The block drives only 0 or z.
- reg_addr  out  7  register address of the last completed write.
- reg_data  out  9  register data of the last completed write.
- wr_en  out  1  one-cycle strobe; reg_addr/reg_data are valid in the same cycle.
- busy  out  1  high from an addressed START until STOP or abort.
- abort  out  1  one-cycle pulse when an addressed frame ends before byte-2 ACK completes.

## Operation
- Start and stop detection:
  - START is an SDA fall while SCL is high. It always enters ADDR; a repeated START is treated the same.
  - STOP is an SDA rise while SCL is high. It always enters IDLE.
- Bit sampling: bits are shifted MSB-first on SCL rising edges; a bit counter spans 0..7.
- States:
  - IDLE.
  - ADDR: takes 8 bits. The 7 MSBs must equal DEV_ADDR and the R/W bit must be 0, which goes to A_ACK; anything else goes to IGNORE without ACK.
  - A_ACK → B1 (8 bits: reg_addr[6:0] plus data bit 8) → K1 → B2 (data bits 7:0) → K2 → EXTRA.
  - EXTRA: further bytes are not ACKed (SDA stays z); the block stays in EXTRA until STOP/START.
  - IGNORE: SDA is never driven; exits only on STOP/START.
- ACK drive:
  - In A_ACK, K1 and K2, SDA is pulled low starting at the SCL falling edge after the 8th bit.
  - SDA is released at the next SCL falling edge, which ends the ACK clock.
- wr_en:
  - Pulses exactly once per frame, at the release edge of K2.
  - reg_addr and reg_data are updated in that same cycle and hold until the next frame.
- abort:
  - Fires when STOP/START arrives during A_ACK, B1, K1, B2 or K2.
  - On abort: no wr_en, reg_addr/reg_data unchanged, busy drops.
- busy: asserted on entry to A_ACK, deasserted on entry to IDLE or IGNORE.

## Timing
- Reset values:
  - State IDLE, SDA released (z).
  - reg_addr = 0, reg_data = 0.
  - wr_en, busy, abort = 0.
  - Synchronizer flops are reset to 1.
- Reset is asynchronous and releases SDA immediately, including mid-ACK. The block then waits for a fresh START; a frame in flight is not resumed.
- Input latency: SYNC_STAGES + 1 cycles from a pin change to the internal edge pulse.
- SDA is driven within SYNC_STAGES + 2 cycles of the SCL fall. This must fall inside the master's SCL low half-period (guaranteed by the 20× ratio).
- Simultaneous events:
  - START/STOP detection takes priority over a data sample in the same cycle.
  - An SCL edge coincident with an SDA change is not a START/STOP; SDA is qualified by the registered SCL level.
- A STOP seen in IDLE is ignored.

## Structure
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, A_ACK, B1, K1, B2, K2, EXTRA, IGNORE);
  - the default codec address constant 7'h1A;
  - localparams for the field splits: addr = word[15:9], data = word[8:0].
- Sub-module i2c_line_sync, instantiated once per line for SCL and SDA:
  - SYNC_STAGES-flop synchronizer plus an output register;
  - outputs the level, a rise pulse and a fall pulse.

## Test plan
- Frame 8'h34, 8'h08, 8'h12, then STOP:
  - three ACK lows;
  - wr_en is one cycle, with reg_addr = 7'h04 and reg_data = 9'h012;
  - busy drops after STOP.
- Frame 8'h34, 8'h1E, 8'h00 (codec reset register):
  - reg_addr = 7'h0F, reg_data = 9'h000;
  - then a frame 8'h34, 8'h0D, 8'hFF gives reg_addr = 7'h06, reg_data = 9'h1FF.
- Address 8'h36, and separately 8'h35 (read):
  - no ACK, SDA never driven;
  - no wr_en, busy stays 0.
- STOP injected after the 3rd bit of byte 2:
  - abort pulses once;
  - no wr_en;
  - reg_addr/reg_data keep their prior values.
- Repeated START after byte 1, then a full valid frame:
  - abort pulses for the first frame;
  - the second frame produces a correct wr_en.
- rst asserted while SDA is held low in K1:
  - SDA goes z within 1 cycle;
  - all outputs return to their reset values;
  - a following valid frame is accepted.
